// File: rtl/park_pkg.sv
// Shared types and arithmetic helpers for the Park transform pipeline.
// Internal datapath is sized for the widest supported D_WIDTH; narrower instances sign-extend into it.
package park_pkg;

    localparam int PARK_DW_MAX = 32;
    localparam int PARK_PW     = 2 * PARK_DW_MAX;
    localparam int PARK_SW     = PARK_PW + 1;

    typedef enum logic {
        PARK_INV = 1'b0,
        PARK_FWD = 1'b1
    } park_mode_e;

    // Stage-1 payload: the four cross products of (x, y) with (cos, sin).
    typedef struct packed {
        park_mode_e                 mode;
        logic signed [PARK_PW-1:0]  xc;
        logic signed [PARK_PW-1:0]  ys;
        logic signed [PARK_PW-1:0]  xs;
        logic signed [PARK_PW-1:0]  yc;
    } park_prod_t;

    // Stage-2 payload: rounded, rescaled sums before clipping.
    typedef struct packed {
        logic signed [PARK_SW-1:0]  a;
        logic signed [PARK_SW-1:0]  b;
    } park_sum_t;

    function automatic logic signed [PARK_SW-1:0] park_round_const(input int unsigned q);
        logic signed [PARK_SW-1:0] r;
        r = '0;
        r[q-1] = 1'b1;
        return r;
    endfunction

    // Returns {clip, value}; only the low w bits of value are meaningful.
    function automatic logic [PARK_DW_MAX:0] park_saturate(
        input logic signed [PARK_SW-1:0] v,
        input int unsigned               w
    );
        logic signed [PARK_SW-1:0] hi;
        logic signed [PARK_SW-1:0] lo;
        hi = '0;
        hi[w-1] = 1'b1;
        hi = hi - PARK_SW'(1);
        lo = ~hi;
        if (v > hi) begin
            return {1'b1, hi[PARK_DW_MAX-1:0]};
        end else if (v < lo) begin
            return {1'b1, lo[PARK_DW_MAX-1:0]};
        end
        return {1'b0, v[PARK_DW_MAX-1:0]};
    endfunction

endpackage

// File: rtl/park_xform_pipe_sat.sv
// Combinational signed saturator: wide rescaled sum to D_WIDTH with a clip flag.
module park_sat
    import park_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic signed [PARK_SW-1:0]  value,
    output logic signed [D_WIDTH-1:0]  result,
    output logic                       clip
);

    logic [PARK_DW_MAX:0] packed_res;

    assign packed_res = park_saturate(value, D_WIDTH);
    assign result     = packed_res[D_WIDTH-1:0];
    assign clip       = packed_res[PARK_DW_MAX];

endmodule

// File: rtl/park_xform_pipe.sv
// Three-stage inverse/forward Park transform: multiply, round-and-shift, saturate.
// Valid/ready with per-stage advance so bubbles collapse; in_ready is combinational from out_ready.
module park_xform_pipe
    import park_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int Q_BITS  = 10,
    parameter int CH_BITS = 2
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode,
    input  logic [CH_BITS-1:0]         in_ch,
    input  logic signed [D_WIDTH-1:0]  in_x,
    input  logic signed [D_WIDTH-1:0]  in_y,
    input  logic signed [D_WIDTH-1:0]  in_sin,
    input  logic signed [D_WIDTH-1:0]  in_cos,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_BITS-1:0]         out_ch,
    output logic signed [D_WIDTH-1:0]  out_a,
    output logic signed [D_WIDTH-1:0]  out_b,
    output logic                       out_sat
);

    localparam int PW = 2 * D_WIDTH;

    logic               v1, v2;
    park_prod_t         s1;
    park_sum_t          s2;
    logic [CH_BITS-1:0] ch1, ch2;

    logic adv1, adv2, adv3;

    // A stage can take new data if it is empty or its occupant moves on this edge.
    assign adv3     = !out_valid || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    logic signed [PW-1:0] p_xc, p_ys, p_xs, p_yc;

    assign p_xc = PW'(in_x) * PW'(in_cos);
    assign p_ys = PW'(in_y) * PW'(in_sin);
    assign p_xs = PW'(in_x) * PW'(in_sin);
    assign p_yc = PW'(in_y) * PW'(in_cos);

    logic signed [PARK_SW-1:0] sum_a, sum_b, rnd_a, rnd_b;

    always_comb begin
        sum_a = '0;
        sum_b = '0;
        if (s1.mode == PARK_INV) begin
            sum_a = PARK_SW'(s1.xc) - PARK_SW'(s1.ys);
            sum_b = PARK_SW'(s1.xs) + PARK_SW'(s1.yc);
        end else begin
            sum_a = PARK_SW'(s1.xc) + PARK_SW'(s1.ys);
            sum_b = PARK_SW'(s1.yc) - PARK_SW'(s1.xs);
        end
    end

    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    assign rnd_a = (sum_a + park_round_const(Q_BITS)) >>> Q_BITS;
    assign rnd_b = (sum_b + park_round_const(Q_BITS)) >>> Q_BITS;

    logic signed [D_WIDTH-1:0] sat_a_val, sat_b_val;
    logic                      clip_a, clip_b;

    park_sat #(.D_WIDTH(D_WIDTH)) u_sat_a (
        .value  (s2.a),
        .result (sat_a_val),
        .clip   (clip_a)
    );

    park_sat #(.D_WIDTH(D_WIDTH)) u_sat_b (
        .value  (s2.b),
        .result (sat_b_val),
        .clip   (clip_b)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            v1  <= 1'b0;
            s1  <= '0;
            ch1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1.mode <= park_mode_e'(in_mode);
                s1.xc   <= PARK_PW'(p_xc);
                s1.ys   <= PARK_PW'(p_ys);
                s1.xs   <= PARK_PW'(p_xs);
                s1.yc   <= PARK_PW'(p_yc);
                ch1     <= in_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            v2  <= 1'b0;
            s2  <= '0;
            ch2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                s2.a <= rnd_a;
                s2.b <= rnd_b;
                ch2  <= ch1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (adv3) begin
            out_valid <= v2;
            if (v2) begin
                out_a   <= sat_a_val;
                out_b   <= sat_b_val;
                out_ch  <= ch2;
                out_sat <= clip_a | clip_b;
            end
        end
    end

endmodule

// File: tb/tb_park_xform_pipe.sv
// Directed and randomized checks of park_xform_pipe against an arbitrary-precision reference.
module tb_park_xform_pipe;

    localparam int QB = 10;

    logic clk = 1'b0;
    logic rstb;
    logic in_valid, in_mode, out_ready;
    logic [1:0] in_ch;
    logic signed [31:0] in_x, in_y, in_sin, in_cos;
    logic in_ready, out_valid, out_sat;
    logic [1:0] out_ch;
    logic signed [31:0] out_a, out_b;

    logic d16_in_ready, d16_out_valid, d16_out_sat;
    logic [1:0] d16_out_ch;
    logic signed [15:0] d16_out_a, d16_out_b;

    int checks = 0;
    int failures = 0;

    logic              tx_mode [32];
    logic [1:0]        tx_ch   [32];
    logic signed [31:0] tx_x [32], tx_y [32], tx_s [32], tx_c [32];

    always #5 clk = ~clk;

    park_xform_pipe #(.D_WIDTH(32), .Q_BITS(QB), .CH_BITS(2)) dut (
        .clk(clk), .rstb(rstb),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_ch(in_ch),
        .in_x(in_x), .in_y(in_y), .in_sin(in_sin), .in_cos(in_cos),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_a(out_a), .out_b(out_b), .out_sat(out_sat)
    );

    park_xform_pipe #(.D_WIDTH(16), .Q_BITS(QB), .CH_BITS(2)) dut16 (
        .clk(clk), .rstb(rstb),
        .in_valid(in_valid), .in_ready(d16_in_ready), .in_mode(in_mode), .in_ch(in_ch),
        .in_x(in_x[15:0]), .in_y(in_y[15:0]), .in_sin(in_sin[15:0]), .in_cos(in_cos[15:0]),
        .out_valid(d16_out_valid), .out_ready(out_ready), .out_ch(d16_out_ch),
        .out_a(d16_out_a), .out_b(d16_out_b), .out_sat(d16_out_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Round-half-up division by 2^QB using floor division on exact integers.
    function automatic logic signed [127:0] rdiv(input logic signed [127:0] v);
        logic signed [127:0] n, d, q;
        n = v + (128'sd1 <<< (QB - 1));
        d = 128'sd1 <<< QB;
        q = n / d;
        if (n < 0 && q * d != n) q = q - 128'sd1;
        return q;
    endfunction

    function automatic void model(input logic mode, input logic signed [31:0] x, y, s, c,
                                  input int dw, output logic signed [31:0] ra, rb, output logic sat);
        logic signed [127:0] xx, yy, ss, cc, a, b, lim;
        logic sa, sb;
        xx = x; yy = y; ss = s; cc = c;
        if (!mode) begin
            a = xx * cc - yy * ss;
            b = xx * ss + yy * cc;
        end else begin
            a = xx * cc + yy * ss;
            b = yy * cc - xx * ss;
        end
        a = rdiv(a);
        b = rdiv(b);
        lim = 128'sd1 <<< (dw - 1);
        sa = 1'b0; sb = 1'b0;
        if (a > lim - 128'sd1) begin a = lim - 128'sd1; sa = 1'b1; end
        else if (a < -lim) begin a = -lim; sa = 1'b1; end
        if (b > lim - 128'sd1) begin b = lim - 128'sd1; sb = 1'b1; end
        else if (b < -lim) begin b = -lim; sb = 1'b1; end
        ra = a[31:0];
        rb = b[31:0];
        sat = sa | sb;
    endfunction

    task automatic run_one(input string tag, input logic mode, input logic [1:0] ch,
                           input logic signed [31:0] x, y, s, c,
                           input logic signed [31:0] ea, eb, input logic esat);
        int n;
        @(negedge clk);
        in_mode = mode; in_ch = ch; in_x = x; in_y = y; in_sin = s; in_cos = c;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_a"}, out_a, ea);
        check({tag, "_b"}, out_b, eb);
        check({tag, "_ch"}, out_ch, ch);
        check({tag, "_sat"}, out_sat, esat);
    endtask

    task automatic gen(input int n, input logic seq_ch);
        for (int i = 0; i < n; i++) begin
            tx_mode[i] = 1'($urandom_range(0, 1));
            tx_ch[i]   = seq_ch ? 2'(i % 4) : 2'($urandom_range(0, 3));
            tx_x[i]    = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 20000)) - 10000);
            tx_y[i]    = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 20000)) - 10000);
            tx_s[i]    = ($urandom_range(0, 4) == 0) ? $urandom : 32'(int'($urandom_range(0, 2048)) - 1024);
            tx_c[i]    = ($urandom_range(0, 4) == 0) ? $urandom : 32'(int'($urandom_range(0, 2048)) - 1024);
        end
    endtask

    // hold > 0: keep out_ready low for that many cycles to fill the pipeline first.
    task automatic run_stream(input string tag, input int n, input int hold);
        logic signed [31:0] qa[$], qb[$];
        logic [1:0]         qc[$];
        logic               qs[$];
        logic signed [31:0] ma, mb, held_a;
        logic               ms, acc, emit;
        int i, got;
        i = 0; got = 0; held_a = '0;
        for (int cyc = 0; cyc < 600 && got < n; cyc++) begin
            @(negedge clk);
            if (cyc < hold) out_ready = 1'b0;
            else if (cyc == hold) out_ready = 1'b1;
            else out_ready = 1'($urandom_range(0, 1));
            in_valid = (i < n);
            if (i < n) begin
                in_mode = tx_mode[i]; in_ch = tx_ch[i];
                in_x = tx_x[i]; in_y = tx_y[i]; in_sin = tx_s[i]; in_cos = tx_c[i];
            end
            #1;
            if (hold > 0 && cyc == 3) held_a = out_a;
            if (hold > 0 && cyc == hold - 1) begin
                check({tag, "_accepted"}, i, 3);
                check({tag, "_in_ready_full"}, in_ready, 0);
                check({tag, "_out_valid_held"}, out_valid, 1);
                check({tag, "_a_stable"}, out_a, held_a);
                check({tag, "_ch_head"}, out_ch, 0);
            end
            if (hold > 0 && cyc == hold) check({tag, "_in_ready_release"}, in_ready, 1);
            acc  = in_valid && in_ready;
            emit = out_valid && out_ready;
            if (emit) begin
                if (qa.size() == 0) begin
                    check({tag, "_spurious_out"}, 1, 0);
                end else begin
                    check({tag, "_a"}, out_a, qa.pop_front());
                    check({tag, "_b"}, out_b, qb.pop_front());
                    check({tag, "_ch"}, out_ch, qc.pop_front());
                    check({tag, "_sat"}, out_sat, qs.pop_front());
                end
                got++;
            end
            if (acc) begin
                model(tx_mode[i], tx_x[i], tx_y[i], tx_s[i], tx_c[i], 32, ma, mb, ms);
                qa.push_back(ma); qb.push_back(mb); qc.push_back(tx_ch[i]); qs.push_back(ms);
                i++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        rstb = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_ch = '0; out_ready = 1'b0;
        in_x = '0; in_y = '0; in_sin = '0; in_cos = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_a", out_a, 0);
        check("rst_b", out_b, 0);
        check("rst_ch", out_ch, 0);
        check("rst_sat", out_sat, 0);
        @(negedge clk);
        rstb = 1'b1;

        run_one("identity", 1'b0, 2'd1, 32'sd1024, 32'sd0, 32'sd0, 32'sd1024, 32'sd1024, 32'sd0, 1'b0);
        run_one("inv90", 1'b0, 2'd2, 32'sd512, 32'sd256, 32'sd1024, 32'sd0, -32'sd256, 32'sd512, 1'b0);
        run_one("fwd90", 1'b1, 2'd3, -32'sd256, 32'sd512, 32'sd1024, 32'sd0, 32'sd512, 32'sd256, 1'b0);
        run_one("round_pos", 1'b0, 2'd0, 32'sd1, 32'sd0, 32'sd0, 32'sd512, 32'sd1, 32'sd0, 1'b0);
        run_one("round_neg", 1'b0, 2'd0, -32'sd1, 32'sd0, 32'sd0, 32'sd512, 32'sd0, 32'sd0, 1'b0);
        run_one("round_3", 1'b0, 2'd0, 32'sd3, 32'sd0, 32'sd0, 32'sd512, 32'sd2, 32'sd0, 1'b0);

        run_one("sat_hi32", 1'b0, 2'd1, 32'sd32767, -32'sd32768, 32'sd1024, 32'sd1024, 32'sd65535, -32'sd1, 1'b0);
        check("sat_hi16_a", d16_out_a, 32767);
        check("sat_hi16_b", d16_out_b, -1);
        check("sat_hi16_sat", d16_out_sat, 1);
        run_one("sat_lo32", 1'b0, 2'd2, -32'sd32768, 32'sd32767, 32'sd1024, 32'sd1024, -32'sd65535, -32'sd1, 1'b0);
        check("sat_lo16_a", d16_out_a, -32768);
        check("sat_lo16_b", d16_out_b, -1);
        check("sat_lo16_sat", d16_out_sat, 1);

        gen(5, 1'b1);
        run_stream("bp", 5, 8);
        gen(24, 1'b0);
        run_stream("mix", 24, 0);

        gen(2, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_mode = tx_mode[k]; in_ch = tx_ch[k];
            in_x = tx_x[k]; in_y = tx_y[k]; in_sin = tx_s[k]; in_cos = tx_c[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rstb = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_a", out_a, 0);
        check("mid_rst_b", out_b, 0);
        check("mid_rst_ch", out_ch, 0);
        check("mid_rst_sat", out_sat, 0);
        @(negedge clk);
        rstb = 1'b1;
        out_ready = 1'b1;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check("mid_rst_no_ghost", quiet, 0);
        run_one("post_rst", 1'b0, 2'd3, 32'sd1024, 32'sd0, 32'sd0, 32'sd1024, 32'sd1024, 32'sd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
